// File: rtl/fiat_25519_carry_square_mul_arb.sv
// Round-robin arbiter that shares one A*B multiplier among NUM_REQ requesters.
// Products are queued in a 2-entry FIFO tagged with the issuing requester id.
module fiat_25519_carry_square_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 39,
  parameter int B_WIDTH = 6,
  parameter int P_WIDTH = 44,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  output logic [P_WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]            res_id,
  input  logic                       res_ready,
  output logic [15:0]                ops_done
);

  localparam int FW = A_WIDTH + B_WIDTH;
  localparam int MW = (FW > P_WIDTH) ? FW : P_WIDTH;

  logic [1:0]         cnt_q, cnt_d;
  logic               head_q, head_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [15:0]        ops_q, ops_d;
  logic [P_WIDTH-1:0] mem_data_q [2];
  logic [ID_W-1:0]    mem_id_q   [2];

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic               grant_en;
  logic               push;
  logic               pop;
  logic               tail;
  logic [A_WIDTH-1:0] op_a;
  logic [B_WIDTH-1:0] op_b;
  logic [P_WIDTH-1:0] prod;

  // First valid requester at or after rr_q, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign res_valid = (cnt_q != 2'd0);
  assign pop       = res_valid && res_ready;
  assign grant_en  = (cnt_q < 2'd2) || pop;

  always_comb begin
    req_ready = '0;
    if (grant_en && gnt_found && !ap_rst)
      req_ready = NUM_REQ'(1) << gnt_idx;
  end

  assign push = |(req_valid & req_ready);

  assign op_a = req_a[gnt_idx*A_WIDTH +: A_WIDTH];
  assign op_b = req_b[gnt_idx*B_WIDTH +: B_WIDTH];
  assign prod = P_WIDTH'(MW'(op_a) * MW'(op_b));

  // With count==2 the tail slot is the head being popped this cycle.
  assign tail = head_q ^ cnt_q[0];

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    rr_d   = rr_q;
    ops_d  = ops_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (pop) begin
      head_d = ~head_q;
      ops_d  = ops_q + 16'd1;
    end
    if (push)
      rr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt_q  <= '0;
      head_q <= 1'b0;
      rr_q   <= '0;
      ops_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      rr_q   <= rr_d;
      ops_q  <= ops_d;
      if (push) begin
        mem_data_q[tail] <= prod;
        mem_id_q[tail]   <= gnt_idx;
      end
    end
  end

  assign res_data = res_valid ? mem_data_q[head_q] : '0;
  assign res_id   = res_valid ? mem_id_q[head_q]   : '0;
  assign ops_done = ops_q;

endmodule

// File: tb/tb_fiat_25519_carry_square_mul_arb.sv
// Directed bench for the shared-multiplier arbiter.
// Covers reset, latency, truncation, round-robin, backpressure, wrap.
module tb_fiat_25519_carry_square_mul_arb;

  localparam int NR = 4;
  localparam int AW = 39;
  localparam int BW = 6;
  localparam int PW = 44;

  logic          ap_clk;
  logic          ap_rst;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_a;
  logic [NR*BW-1:0] req_b;
  logic [NR-1:0] req_ready;
  logic          res_valid;
  logic [PW-1:0] res_data;
  logic [1:0]    res_id;
  logic          res_ready;
  logic [15:0]   ops_done;

  int n_vec;
  int n_err;

  fiat_25519_carry_square_mul_arb #(
    .NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_id(res_id),
    .res_ready(res_ready),
    .ops_done(ops_done)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [63:0] prod_tbl [NR];

  initial begin
    n_vec = 0;
    n_err = 0;
    ap_rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    prod_tbl[0] = 64'd300;
    prod_tbl[1] = 64'd800;
    prod_tbl[2] = 64'd1500;
    prod_tbl[3] = 64'd2400;

    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = 4'hF;
    #1;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_ops_done", 64'(ops_done), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    req_valid = '0;

    // single operation
    @(negedge ap_clk);
    ap_rst = 1'b0;
    req_valid = 4'b0001;
    req_a[0 +: AW] = 39'd1000;
    req_b[0 +: BW] = 6'd25;
    res_ready = 1'b1;
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_empty", 64'(res_valid), 64'd0);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("single_valid", 64'(res_valid), 64'd1);
    check("single_data", 64'(res_data), 64'h61A8);
    check("single_id", 64'(res_id), 64'd0);
    @(negedge ap_clk);
    #1;
    check("single_ops", 64'(ops_done), 64'd1);
    check("single_drain", 64'(res_valid), 64'd0);

    // truncation of the 45-bit product
    req_valid = 4'b0001;
    req_a[0 +: AW] = '1;
    req_b[0 +: BW] = 6'd63;
    #1;
    check("trunc_ready", 64'(req_ready), 64'h1);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("trunc_data", 64'(res_data), 64'hF7F_FFFF_FFC1);
    @(negedge ap_clk);
    #1;
    check("trunc_ops", 64'(ops_done), 64'd2);

    // round-robin with all requesters asserted
    ap_rst = 1'b1;
    #1;
    ap_rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*AW +: AW] = AW'(100 * (i + 1));
      req_b[i*BW +: BW] = BW'(i + 3);
    end
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("rr_ready%0d", c), 64'(req_ready),
            64'(4'b0001 << (c % NR)));
      if (c > 0) begin
        check($sformatf("rr_id%0d", c), 64'(res_id), 64'((c - 1) % NR));
        check($sformatf("rr_data%0d", c), 64'(res_data),
              prod_tbl[(c - 1) % NR]);
      end
      @(negedge ap_clk);
    end
    req_valid = '0;
    #1;
    check("rr_last_id", 64'(res_id), 64'd0);
    check("rr_last_data", 64'(res_data), 64'd300);
    @(negedge ap_clk);
    #1;
    check("rr_drain", 64'(res_valid), 64'd0);
    check("rr_ops", 64'(ops_done), 64'd5);

    // backpressure: fill, stall, then one pop with one accept
    res_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    check("bp_ready0", 64'(req_ready), 64'h2);
    @(negedge ap_clk);
    #1;
    check("bp_ready1", 64'(req_ready), 64'h4);
    check("bp_id1", 64'(res_id), 64'd1);
    @(negedge ap_clk);
    #1;
    check("bp_full_ready", 64'(req_ready), 64'd0);
    check("bp_full_data", 64'(res_data), 64'd800);
    @(negedge ap_clk);
    #1;
    check("bp_hold_ready", 64'(req_ready), 64'd0);
    check("bp_hold_id", 64'(res_id), 64'd1);
    check("bp_hold_data", 64'(res_data), 64'd800);
    res_ready = 1'b1;
    #1;
    check("bp_pop_ready", 64'(req_ready), 64'h8);
    @(negedge ap_clk);
    res_ready = 1'b0;
    #1;
    check("bp_after_valid", 64'(res_valid), 64'd1);
    check("bp_after_id", 64'(res_id), 64'd2);
    check("bp_after_data", 64'(res_data), 64'd1500);
    check("bp_after_ready", 64'(req_ready), 64'd0);
    check("bp_after_ops", 64'(ops_done), 64'd6);

    // asynchronous reset with the FIFO full
    #2;
    ap_rst = 1'b1;
    #1;
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd0);
    check("arst_ops", 64'(ops_done), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    res_ready = 1'b1;
    #1;
    check("arst_first", 64'(req_ready), 64'h1);

    // counter wrap: first edge accepts, each later edge pops one
    repeat (65536) @(posedge ap_clk);
    #2;
    check("wrap_ffff", 64'(ops_done), 64'hFFFF);
    @(posedge ap_clk);
    #2;
    check("wrap_zero", 64'(ops_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
